// File: rtl/battle_turn_ctl.sv
// Turn-flow controller for the two-player battleship game: cursor-to-grid mapping,
// placement/aim/fire/result/defend/reply/over sequencing and hit scoring.
// Optional REPEAT_GUARD_EN keeps a fired-cell bitmap and ignores repeat shots.
module battle_turn_ctl #(
  parameter int unsigned GRID_W      = 10,
  parameter int unsigned GRID_H      = 10,
  parameter int unsigned CELL_PX     = 32,
  parameter int unsigned ORIGIN_X    = 608,
  parameter int unsigned ORIGIN_Y    = 193,
  parameter int unsigned FLEET_CELLS = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        first_player,
  input  logic [3:0]  placed_count,
  output logic        cursor_valid,
  output logic [7:0]  cursor_coord,
  output logic        place_en,
  output logic        shot_valid,
  output logic [7:0]  shot_coord,
  input  logic        shot_ready,
  input  logic        res_valid,
  input  logic        res_hit,
  input  logic        in_valid,
  input  logic [7:0]  in_coord,
  output logic [7:0]  lookup_coord,
  input  logic        lookup_hit,
  output logic        reply_valid,
  output logic        reply_hit,
  input  logic        reply_ready,
  output logic [3:0]  hits_scored,
  output logic [3:0]  hits_taken,
  output logic [2:0]  state_code,
  output logic        game_over,
  output logic        win
);

  localparam int unsigned SHIFT = $clog2(CELL_PX);
  localparam int unsigned X_END = ORIGIN_X + GRID_W * CELL_PX;
  localparam int unsigned Y_END = ORIGIN_Y + GRID_H * CELL_PX;
  localparam logic [3:0]  FLEET = 4'(FLEET_CELLS);

  typedef enum logic [2:0] {
    S_PLACE  = 3'd0,
    S_ARM    = 3'd1,
    S_AIM    = 3'd2,
    S_FIRE   = 3'd3,
    S_RESULT = 3'd4,
    S_DEFEND = 3'd5,
    S_REPLY  = 3'd6,
    S_OVER   = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic        mouse_left_q;
  logic        place_en_q, place_en_d;
  logic        shot_valid_q, shot_valid_d;
  logic [7:0]  shot_coord_q, shot_coord_d;
  logic        reply_valid_q, reply_valid_d;
  logic        reply_hit_q, reply_hit_d;
  logic [3:0]  hits_scored_q, hits_scored_d;
  logic [3:0]  hits_taken_q, hits_taken_d;
  logic        game_over_q, game_over_d;
  logic        win_q, win_d;

  logic        in_x_c, in_y_c;
  logic [3:0]  cur_col_c, cur_row_c;
  logic        click_c;
  logic        repeat_c;

  // Pixel to grid cell; coordinate reads as zero off-grid
  always_comb begin
    in_x_c       = (32'(mouse_xpos) >= ORIGIN_X) && (32'(mouse_xpos) < X_END);
    in_y_c       = (32'(mouse_ypos) >= ORIGIN_Y) && (32'(mouse_ypos) < Y_END);
    cur_col_c    = 4'((32'(mouse_xpos) - ORIGIN_X) >> SHIFT);
    cur_row_c    = 4'((32'(mouse_ypos) - ORIGIN_Y) >> SHIFT);
    cursor_valid = in_x_c & in_y_c;
    cursor_coord = cursor_valid ? {cur_row_c, cur_col_c} : 8'h00;
  end

  assign click_c      = mouse_left & ~mouse_left_q;
  assign lookup_coord = in_coord;

`ifdef REPEAT_GUARD_EN
  localparam int unsigned CELLS = GRID_W * GRID_H;
  localparam int unsigned IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  logic [CELLS-1:0] fired_q;
  logic [IDX_W-1:0] cur_idx_c;
  logic [IDX_W-1:0] shot_idx_c;

  assign cur_idx_c  = IDX_W'(32'(cur_row_c) * GRID_W + 32'(cur_col_c));
  assign shot_idx_c = IDX_W'(32'(shot_coord_q[7:4]) * GRID_W + 32'(shot_coord_q[3:0]));
  assign repeat_c   = fired_q[cur_idx_c];

  // A cell is marked only once the link layer has taken the shot
  always_ff @(posedge clk) begin
    if (rst) begin
      fired_q <= '0;
    end else if (shot_valid_q && shot_ready) begin
      fired_q[shot_idx_c] <= 1'b1;
    end
  end
`else
  assign repeat_c = 1'b0;
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    shot_valid_d  = shot_valid_q;
    shot_coord_d  = shot_coord_q;
    reply_valid_d = reply_valid_q;
    reply_hit_d   = reply_hit_q;
    hits_scored_d = hits_scored_q;
    hits_taken_d  = hits_taken_q;
    win_d         = win_q;

    case (state_q)
      S_PLACE: begin
        if (placed_count == FLEET && !mouse_left) state_d = S_ARM;
      end
      S_ARM: begin
        state_d = first_player ? S_AIM : S_DEFEND;
      end
      S_AIM: begin
        if (click_c && cursor_valid && !repeat_c) begin
          shot_coord_d = cursor_coord;
          shot_valid_d = 1'b1;
          state_d      = S_FIRE;
        end
      end
      S_FIRE: begin
        if (shot_valid_q && shot_ready) begin
          shot_valid_d = 1'b0;
          state_d      = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_valid) begin
          if (res_hit && hits_scored_q < FLEET) hits_scored_d = hits_scored_q + 4'd1;
          if (hits_scored_d == FLEET) begin
            state_d = S_OVER;
            win_d   = 1'b1;
          end else begin
            state_d = S_DEFEND;
          end
        end
      end
      S_DEFEND: begin
        if (in_valid) begin
          reply_hit_d   = lookup_hit;
          reply_valid_d = 1'b1;
          if (lookup_hit && hits_taken_q < FLEET) hits_taken_d = hits_taken_q + 4'd1;
          state_d       = S_REPLY;
        end
      end
      S_REPLY: begin
        if (reply_ready) begin
          reply_valid_d = 1'b0;
          if (hits_taken_q == FLEET) begin
            state_d = S_OVER;
            win_d   = 1'b0;
          end else begin
            state_d = S_AIM;
          end
        end
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_PLACE;
      end
    endcase

    place_en_d  = (state_d == S_PLACE);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_PLACE;
      mouse_left_q  <= 1'b0;
      place_en_q    <= 1'b0;
      shot_valid_q  <= 1'b0;
      shot_coord_q  <= 8'h00;
      reply_valid_q <= 1'b0;
      reply_hit_q   <= 1'b0;
      hits_scored_q <= 4'd0;
      hits_taken_q  <= 4'd0;
      game_over_q   <= 1'b0;
      win_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      mouse_left_q  <= mouse_left;
      place_en_q    <= place_en_d;
      shot_valid_q  <= shot_valid_d;
      shot_coord_q  <= shot_coord_d;
      reply_valid_q <= reply_valid_d;
      reply_hit_q   <= reply_hit_d;
      hits_scored_q <= hits_scored_d;
      hits_taken_q  <= hits_taken_d;
      game_over_q   <= game_over_d;
      win_q         <= win_d;
    end
  end

  assign place_en    = place_en_q;
  assign shot_valid  = shot_valid_q;
  assign shot_coord  = shot_coord_q;
  assign reply_valid = reply_valid_q;
  assign reply_hit   = reply_hit_q;
  assign hits_scored = hits_scored_q;
  assign hits_taken  = hits_taken_q;
  assign state_code  = state_q;
  assign game_over   = game_over_q;
  assign win         = win_q;

endmodule

// File: tb/tb_battle_turn_ctl.sv
// Directed bench for battle_turn_ctl: win path, loss path, cursor edges, stray strobes,
// reset mid-handshake and the REPEAT_GUARD_EN behaviour (both builds).
module tb_battle_turn_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mouse_left;
  logic [11:0] mouse_xpos, mouse_ypos;
  logic        first_player;
  logic [3:0]  placed_count;
  logic        cursor_valid;
  logic [7:0]  cursor_coord;
  logic        place_en;
  logic        shot_valid;
  logic [7:0]  shot_coord;
  logic        shot_ready;
  logic        res_valid, res_hit;
  logic        in_valid;
  logic [7:0]  in_coord;
  logic [7:0]  lookup_coord;
  logic        lookup_hit;
  logic        reply_valid, reply_hit, reply_ready;
  logic [3:0]  hits_scored, hits_taken;
  logic [2:0]  state_code;
  logic        game_over, win;

  int n_vec = 0;
  int n_err = 0;
  int exp_scored = 0;
  int exp_taken  = 0;

  logic [7:0] shot_sb[$];
  logic       reply_sb[$];

  always #5 clk = ~clk;

  battle_turn_ctl dut (
    .clk(clk), .rst(rst), .mouse_left(mouse_left), .mouse_xpos(mouse_xpos),
    .mouse_ypos(mouse_ypos), .first_player(first_player), .placed_count(placed_count),
    .cursor_valid(cursor_valid), .cursor_coord(cursor_coord), .place_en(place_en),
    .shot_valid(shot_valid), .shot_coord(shot_coord), .shot_ready(shot_ready),
    .res_valid(res_valid), .res_hit(res_hit), .in_valid(in_valid), .in_coord(in_coord),
    .lookup_coord(lookup_coord), .lookup_hit(lookup_hit), .reply_valid(reply_valid),
    .reply_hit(reply_hit), .reply_ready(reply_ready), .hits_scored(hits_scored),
    .hits_taken(hits_taken), .state_code(state_code), .game_over(game_over), .win(win)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_state"}, 32'(state_code), 32'd0);
    chk({tag, "_place_en"}, 32'(place_en), 32'd0);
    chk({tag, "_shot_valid"}, 32'(shot_valid), 32'd0);
    chk({tag, "_shot_coord"}, 32'(shot_coord), 32'd0);
    chk({tag, "_reply_valid"}, 32'(reply_valid), 32'd0);
    chk({tag, "_reply_hit"}, 32'(reply_hit), 32'd0);
    chk({tag, "_hits_scored"}, 32'(hits_scored), 32'd0);
    chk({tag, "_hits_taken"}, 32'(hits_taken), 32'd0);
    chk({tag, "_game_over"}, 32'(game_over), 32'd0);
    chk({tag, "_win"}, 32'(win), 32'd0);
  endtask

  // Click at a pixel; one-cycle press so the edge detector sees exactly one click
  task automatic click(input int x, input int y);
    mouse_xpos = 12'(x);
    mouse_ypos = 12'(y);
    mouse_left = 1'b1;
    tick();
    mouse_left = 1'b0;
  endtask

  // Aim at a cell, then complete the shot handshake and check the scoreboard entry
  task automatic fire_at(input int x, input int y, input logic [7:0] coord);
    int n;
    shot_sb.push_back(coord);
    click(x, y);
    n = 0;
    while (!shot_valid && n < 20) begin
      tick();
      n++;
    end
    chk("shot_valid_wait", 32'(shot_valid), 32'd1);
    shot_ready = 1'b1;
    chk("shot_sb_size", 32'(shot_sb.size()), 32'd1);
    if (shot_sb.size() != 0) chk("shot_coord", 32'(shot_coord), 32'(shot_sb.pop_front()));
    tick();
    shot_ready = 1'b0;
    chk("shot_drop", 32'(shot_valid), 32'd0);
    chk("state_result", 32'(state_code), 32'd4);
  endtask

  task automatic result(input logic hit);
    res_valid = 1'b1;
    res_hit   = hit;
    tick();
    res_valid = 1'b0;
    res_hit   = 1'b0;
    if (hit && exp_scored < 11) exp_scored++;
    chk("hits_scored", 32'(hits_scored), 32'(exp_scored));
  endtask

  // Incoming shot, reply handshake; scoreboard holds the expected reply payload
  task automatic defend(input logic [7:0] coord, input logic hit);
    int n;
    in_valid   = 1'b1;
    in_coord   = coord;
    lookup_hit = hit;
    #1;
    chk("lookup_coord", 32'(lookup_coord), 32'(coord));
    reply_sb.push_back(hit);
    tick();
    in_valid   = 1'b0;
    lookup_hit = 1'b0;
    if (hit && exp_taken < 11) exp_taken++;
    n = 0;
    while (!reply_valid && n < 20) begin
      tick();
      n++;
    end
    chk("reply_valid_wait", 32'(reply_valid), 32'd1);
    chk("hits_taken", 32'(hits_taken), 32'(exp_taken));
    chk("reply_sb_size", 32'(reply_sb.size()), 32'd1);
    if (reply_sb.size() != 0) chk("reply_hit", 32'(reply_hit), 32'(reply_sb.pop_front()));
    reply_ready = 1'b1;
    tick();
    reply_ready = 1'b0;
    chk("reply_drop", 32'(reply_valid), 32'd0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_scored = 0;
    exp_taken  = 0;
  endtask

  initial begin
    rst = 1'b1; mouse_left = 1'b0; mouse_xpos = '0; mouse_ypos = '0;
    first_player = 1'b1; placed_count = 4'd0; shot_ready = 1'b0;
    res_valid = 1'b0; res_hit = 1'b0; in_valid = 1'b0; in_coord = '0;
    lookup_hit = 1'b0; reply_ready = 1'b0;

    reset_dut();
    #0;
    // First edge out of reset: still PLACE, place_en rises
    tick();
    chk("place_state", 32'(state_code), 32'd0);
    chk("place_en", 32'(place_en), 32'd1);
    placed_count = 4'd11;
    mouse_left   = 1'b1;
    tick();
    chk("place_hold_btn", 32'(state_code), 32'd0);
    mouse_left = 1'b0;
    tick();
    chk("arm_state", 32'(state_code), 32'd1);
    chk("arm_place_en", 32'(place_en), 32'd0);
    tick();
    chk("aim_state", 32'(state_code), 32'd2);
    chk("aim_scored", 32'(hits_scored), 32'd0);
    chk("aim_taken", 32'(hits_taken), 32'd0);

    // Cursor mapping including grid edges
    mouse_xpos = 12'd640; mouse_ypos = 12'd225; #1;
    chk("cur_valid_11", 32'(cursor_valid), 32'd1);
    chk("cur_coord_11", 32'(cursor_coord), 32'h11);
    mouse_xpos = 12'd927; mouse_ypos = 12'd512; #1;
    chk("cur_coord_99", 32'(cursor_coord), 32'h99);
    mouse_xpos = 12'd608; mouse_ypos = 12'd193; #1;
    chk("cur_valid_00", 32'(cursor_valid), 32'd1);
    mouse_xpos = 12'd928; #1;
    chk("cur_valid_xend", 32'(cursor_valid), 32'd0);
    chk("cur_coord_xend", 32'(cursor_coord), 32'd0);
    mouse_xpos = 12'd700; mouse_ypos = 12'd192; #1;
    chk("cur_valid_ylow", 32'(cursor_valid), 32'd0);

    // Shot held while shot_ready is low
    click(640, 225);
    chk("fire_state", 32'(state_code), 32'd3);
    chk("fire_valid", 32'(shot_valid), 32'd1);
    chk("fire_coord", 32'(shot_coord), 32'h11);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fire_hold_valid", 32'(shot_valid), 32'd1);
      chk("fire_hold_coord", 32'(shot_coord), 32'h11);
    end
    shot_sb.push_back(8'h11);
    shot_ready = 1'b1;
    chk("shot_sb_size", 32'(shot_sb.size()), 32'd1);
    if (shot_sb.size() != 0) chk("shot_coord", 32'(shot_coord), 32'(shot_sb.pop_front()));
    tick();
    shot_ready = 1'b0;
    chk("result_state", 32'(state_code), 32'd4);
    chk("result_drop", 32'(shot_valid), 32'd0);

    result(1'b1);
    chk("defend_state", 32'(state_code), 32'd5);
    defend(8'h23, 1'b0);
    chk("back_to_aim", 32'(state_code), 32'd2);

    // Off-grid click and stray strobes in AIM
    mouse_xpos = 12'd500; mouse_ypos = 12'd300; #1;
    chk("off_grid_valid", 32'(cursor_valid), 32'd0);
    click(500, 300);
    chk("off_grid_no_shot", 32'(shot_valid), 32'd0);
    chk("off_grid_state", 32'(state_code), 32'd2);
    in_valid = 1'b1; lookup_hit = 1'b1;
    tick();
    in_valid = 1'b0; lookup_hit = 1'b0;
    res_valid = 1'b1; res_hit = 1'b1;
    tick();
    res_valid = 1'b0; res_hit = 1'b0;
    chk("stray_state", 32'(state_code), 32'd2);
    chk("stray_reply", 32'(reply_valid), 32'd0);
    chk("stray_taken", 32'(hits_taken), 32'd0);
    chk("stray_scored", 32'(hits_scored), 32'd1);

    // Ten more hits to win; some incoming hits along the way
    for (int i = 0; i < 10; i++) begin
      fire_at(608 + i * 32 + 5, 262, {4'd2, 4'(i)});
      result(1'b1);
      if (exp_scored == 11) begin
        chk("win_state", 32'(state_code), 32'd7);
        chk("win_over", 32'(game_over), 32'd1);
        chk("win_flag", 32'(win), 32'd1);
      end else begin
        chk("round_defend", 32'(state_code), 32'd5);
        defend({4'd5, 4'(i)}, 1'(i % 2));
        chk("round_aim", 32'(state_code), 32'd2);
      end
    end

    // Frozen in OVER
    res_valid = 1'b1; res_hit = 1'b1; in_valid = 1'b1; lookup_hit = 1'b1;
    click(640, 225);
    res_valid = 1'b0; res_hit = 1'b0; in_valid = 1'b0; lookup_hit = 1'b0;
    tick();
    chk("over_state", 32'(state_code), 32'd7);
    chk("over_scored", 32'(hits_scored), 32'd11);
    chk("over_taken", 32'(hits_taken), 32'd4);
    chk("over_flag", 32'(game_over), 32'd1);
    chk("over_win", 32'(win), 32'd1);
    chk("over_no_shot", 32'(shot_valid), 32'd0);
    chk("over_no_reply", 32'(reply_valid), 32'd0);

    rst = 1'b1;
    tick();
    chk_idle_outputs("rst_after_win");
    rst = 1'b0;
    exp_scored = 0;
    exp_taken  = 0;

    // Loss path: opponent fires first and lands eleven hits
    first_player = 1'b0;
    tick();
    tick();
    chk("p2_defend", 32'(state_code), 32'd5);
    for (int j = 0; j < 11; j++) begin
      defend({4'd4, 4'(j)}, 1'b1);
      if (exp_taken == 11) begin
        chk("loss_state", 32'(state_code), 32'd7);
        chk("loss_over", 32'(game_over), 32'd1);
        chk("loss_win", 32'(win), 32'd0);
        chk("loss_taken", 32'(hits_taken), 32'd11);
      end else begin
        chk("p2_aim", 32'(state_code), 32'd2);
        fire_at(608 + j * 32 + 1, 290, {4'd3, 4'(j)});
        result(1'b0);
        chk("p2_back_defend", 32'(state_code), 32'd5);
      end
    end

    // Reset in the middle of a shot handshake
    first_player = 1'b1;
    reset_dut();
    tick();
    tick();
    chk("rh_aim", 32'(state_code), 32'd2);
    click(640, 225);
    chk("rh_fire", 32'(shot_valid), 32'd1);
    rst = 1'b1;
    tick();
    chk("rh_drop", 32'(shot_valid), 32'd0);
    chk("rh_state", 32'(state_code), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("rg_aim", 32'(state_code), 32'd2);

    // Repeat shot on an already-fired cell
    fire_at(640, 225, 8'h11);
    result(1'b0);
    defend(8'h30, 1'b0);
    chk("rg_round_aim", 32'(state_code), 32'd2);
    click(640, 225);
`ifdef REPEAT_GUARD_EN
    chk("rg_repeat_blocked", 32'(shot_valid), 32'd0);
    chk("rg_repeat_state", 32'(state_code), 32'd2);
    tick();
    fire_at(672, 225, 8'h12);
`else
    chk("rg_repeat_allowed", 32'(shot_valid), 32'd1);
    chk("rg_repeat_coord", 32'(shot_coord), 32'h11);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/battle_turn_ctl.md
Name: battle_turn_ctl

Overview:
Parametrised game-flow controller for the two-player battleship design. It converts mouse position to a grid coordinate and sequences the turn flow: ship placement, aiming, shot hand-off to the link layer, result wait, defending an incoming shot, and game over. Hits are counted on both sides to declare a winner. It sits between the mouse/VGA front end, the own-board memory and the UART message layer.

Parameters:
GRID_W, 10, columns per board (1..16)
GRID_H, 10, rows per board (1..16)
CELL_PX, 32, cell size in pixels; must be a power of two
ORIGIN_X, 608, pixel x of the target-board left edge
ORIGIN_Y, 193, pixel y of the target-board top edge
FLEET_CELLS, 11, total ship cells per player; also the hit count that ends the game

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
mouse_left  in  1  left button level
mouse_xpos  in  12  cursor x, pixels
mouse_ypos  in  12  cursor y, pixels
first_player  in  1  1 = this board fires first
placed_count  in  4  ship cells placed so far
cursor_valid  out  1  cursor inside the target grid (combinational)
cursor_coord  out  8  {row[3:0], col[3:0]} (combinational)
place_en  out  1  placement mode active
shot_valid  out  1  outgoing shot request
shot_coord  out  8  outgoing shot coordinate
shot_ready  in  1  link layer accepts the shot
res_valid  in  1  opponent result strobe
res_hit  in  1  opponent result: hit
in_valid  in  1  incoming opponent shot strobe
in_coord  in  8  incoming shot coordinate
lookup_coord  out  8  own-board address; equals in_coord, combinational
lookup_hit  in  1  own-board ship bit at lookup_coord, same cycle
reply_valid  out  1  reply to opponent
reply_hit  out  1  reply payload
reply_ready  in  1  link layer accepts the reply
hits_scored  out  4  hits landed on the opponent
hits_taken  out  4  hits received
state_code  out  3  current state, for LEDs/debug
game_over  out  1  game finished
win  out  1  valid when game_over is set

Behaviour:
- Interface: single clock clk; rst is synchronous, active-high. All outputs are registered except cursor_valid, cursor_coord and lookup_coord.
- Reset: state PLACE; every registered output 0; click edge register 0. A reset mid-handshake drops shot_valid/reply_valid on the next edge.
- Cursor: cursor_valid = x>=ORIGIN_X & x<ORIGIN_X+GRID_W*CELL_PX & same test on y. col = (x-ORIGIN_X)>>log2(CELL_PX); row likewise. When cursor_valid=0, cursor_coord = 0.
- Click: click = mouse_left & !mouse_left_q, with a 1-cycle registered edge detect.
- States (state_code): PLACE=0, ARM=1, AIM=2, FIRE=3, RESULT=4, DEFEND=5, REPLY=6, OVER=7.
- PLACE: place_en=1. Go to ARM when placed_count==FLEET_CELLS and mouse_left=0.
- ARM: place_en=0. Go to AIM if first_player=1, else DEFEND.
- AIM: on click with cursor_valid, latch shot_coord=cursor_coord, set shot_valid, go to FIRE. Clicks outside the grid are ignored.
- FIRE: hold shot_valid and shot_coord stable until shot_ready. On the shot_valid&shot_ready cycle, drop shot_valid next cycle and go to RESULT.
- RESULT: on res_valid, hits_scored += res_hit. If the new value == FLEET_CELLS, go to OVER with win=1; else go to DEFEND.
- DEFEND: on in_valid, sample lookup_hit, set reply_hit=lookup_hit and reply_valid=1, go to REPLY. hits_taken += lookup_hit in the same cycle.
- REPLY: hold reply_valid until reply_ready. Then, if hits_taken == FLEET_CELLS, go to OVER with win=0; else go to AIM.
- OVER: game_over=1; state and counters frozen until rst.
- Stray strobes: in_valid outside DEFEND and res_valid outside RESULT are ignored with no state change. Clicks outside AIM are ignored.
- Counters saturate at FLEET_CELLS and never wrap.

Optional Feature:
REPEAT_GUARD_EN. When defined, the block holds a GRID_W*GRID_H fired-cell bitmap, cleared by rst. A cell's bit is set on the shot_valid&shot_ready handshake. In AIM, a click on a cell whose bit is already set is ignored. When undefined, there is no bitmap and repeat shots are allowed.

Test Plan:
- Reset, then placed_count=11, mouse_left=0, first_player=1 -> PLACE, ARM, AIM. state_code=2, all counters 0.
- In AIM, mouse (640,225) and click -> cursor_coord=8'h11, next cycle shot_valid=1, shot_coord=8'h11. shot_ready held low 5 cycles -> shot_valid stays high with stable coord. shot_ready=1 -> RESULT.
- RESULT with res_valid=1, res_hit=1 -> hits_scored=1, state DEFEND. in_valid with in_coord=8'h23 and lookup_hit=0 -> reply_valid=1, reply_hit=0; reply_ready -> AIM, hits_taken stays 0.
- Click at (500,300) in AIM -> cursor_valid=0, no shot_valid, state stays AIM. in_valid pulse in AIM -> no effect.
- Run 11 hit results -> after the 11th, game_over=1, win=1, state_code=7. Further strobes change nothing. rst -> all outputs 0, state PLACE.
- With REPEAT_GUARD_EN: fire 8'h11, complete the round, click (640,225) again in AIM -> no shot_valid. Click (672,225) -> shot_coord=8'h12.
